// File: rtl/ram_arb_pkg.sv
// Shared types and fixed I/O addresses for the RAM port arbiter.
package ram_arb_pkg;

    typedef enum logic [1:0] {CLEAR, IDLE, ACCESS, RESP} state_t;
    typedef enum logic {REQ_A, REQ_B} req_id_t;

    localparam logic [11:0] BTN_ADDR = 12'd0;
    localparam logic [11:0] HEX_ADDR = 12'd1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker; the pointer itself lives in the parent.
module rr_pick2
    import ram_arb_pkg::*;
(
    input  logic    req_a,
    input  logic    req_b,
    input  req_id_t rr_last,
    output logic [1:0] grant,
    output req_id_t rr_next
);

    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        grant   = 2'b00;
        rr_next = rr_last;
        if (req_a && req_b) begin
            // The pointer only moves on a tie, so lone requests never change who wins the next tie.
            if (rr_last == REQ_B) begin
                grant   = 2'b01;
                rr_next = REQ_A;
            end else begin
                grant   = 2'b10;
                rr_next = REQ_B;
            end
        end else if (req_a) begin
            grant = 2'b01;
        end else if (req_b) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates the single-port data RAM between CPU and debug ports, decodes the
// button/display registers and zero-fills the RAM after every reset.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              RAMclr,
    input  logic              a_sel,
    input  logic              a_ld,
    input  logic [11:0]       a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_ready,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [11:0]       b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_ack,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [1:0]        btn,
    output logic [DATA_W-1:0] hex_out,
    output logic              busy
);

    localparam logic [11:0]       DEPTH_A  = 12'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(DEPTH - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    req_id_t             rr_last_q, rr_last_d, rr_next;
    req_id_t             win_q, win_d;
    logic                write_q, write_d;
    logic                ram_q, ram_d;
    logic [11:0]         addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic [DATA_W-1:0]   hex_q, hex_d;
    logic                mem_cs_q, mem_cs_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                a_ready_q, a_ready_d, b_ack_q, b_ack_d;
    logic [DATA_W-1:0]   a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic                busy_q, busy_d;
    logic [1:0]          btn_meta_q, btn_meta_d, btn_sync_q, btn_sync_d;

    logic [1:0]          grant;
    logic                sel_write, sel_is_ram;
    logic [11:0]         sel_addr;
    logic [DATA_W-1:0]   sel_wdata, btn_val, resp_data;

    // A requester whose completion is on the wire this cycle is dropping its
    // request on this edge, so it must not be granted again.
    rr_pick2 u_pick (
        .req_a   (a_sel && !a_ready_q),
        .req_b   (b_req && !b_ack_q),
        .rr_last (rr_last_q),
        .grant   (grant),
        .rr_next (rr_next)
    );

    assign sel_write  = grant[1] ? b_we    : !a_ld;
    assign sel_addr   = grant[1] ? b_addr  : a_addr;
    assign sel_wdata  = grant[1] ? b_wdata : a_wdata;
    assign sel_is_ram = (sel_addr >= 12'd2) && (sel_addr < DEPTH_A);
    assign btn_val    = {{(DATA_W-2){1'b0}}, ~btn_sync_q};

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        rr_last_d   = rr_last_q;
        win_d       = win_q;
        write_d     = write_q;
        ram_d       = ram_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        result_d    = result_q;
        hex_d       = hex_q;
        mem_cs_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        a_ready_d   = 1'b0;
        b_ack_d     = 1'b0;
        a_rdata_d   = a_rdata_q;
        b_rdata_d   = b_rdata_q;
        busy_d      = (state_q == CLEAR);
        btn_meta_d  = btn;
        btn_sync_d  = btn_meta_q;
        resp_data   = '0;

        unique case (state_q)
            CLEAR: begin
                mem_cs_d   = 1'b1;
                mem_we_d   = 1'b1;
                mem_addr_d = clr_cnt_q;
                clr_cnt_d  = clr_cnt_q + ADDR_W'(1);
                if (clr_cnt_q == LAST_CNT) state_d = IDLE;
            end
            IDLE: begin
                // The RAM cycle is launched here so it is on the pins during ACCESS.
                if (grant != 2'b00) begin
                    win_d       = grant[1] ? REQ_B : REQ_A;
                    write_d     = sel_write;
                    addr_d      = sel_addr;
                    wdata_d     = sel_wdata;
                    ram_d       = sel_is_ram;
                    rr_last_d   = rr_next;
                    mem_cs_d    = sel_is_ram;
                    mem_we_d    = sel_is_ram && sel_write;
                    mem_addr_d  = sel_addr[ADDR_W-1:0];
                    mem_wdata_d = sel_is_ram ? sel_wdata : '0;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                if (write_q && addr_q == HEX_ADDR) hex_d = wdata_q;
                result_d = '0;
                if (!write_q && addr_q == BTN_ADDR) result_d = btn_val;
                if (!write_q && addr_q == HEX_ADDR) result_d = hex_q;
                state_d = RESP;
            end
            RESP: begin
                if (!write_q) resp_data = ram_q ? mem_rdata : result_q;
                if (win_q == REQ_A) begin
                    a_ready_d = 1'b1;
                    a_rdata_d = resp_data;
                end else begin
                    b_ack_d   = 1'b1;
                    b_rdata_d = resp_data;
                end
                state_d = IDLE;
            end
            default: state_d = CLEAR;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge RAMclr) begin
        if (RAMclr) begin
            state_q     <= CLEAR;
            clr_cnt_q   <= '0;
            rr_last_q   <= REQ_B;
            win_q       <= REQ_A;
            write_q     <= 1'b0;
            ram_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            result_q    <= '0;
            hex_q       <= '0;
            mem_cs_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            a_ready_q   <= 1'b0;
            b_ack_q     <= 1'b0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
            busy_q      <= 1'b1;
            btn_meta_q  <= 2'b11;
            btn_sync_q  <= 2'b11;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            rr_last_q   <= rr_last_d;
            win_q       <= win_d;
            write_q     <= write_d;
            ram_q       <= ram_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            result_q    <= result_d;
            hex_q       <= hex_d;
            mem_cs_q    <= mem_cs_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            a_ready_q   <= a_ready_d;
            b_ack_q     <= b_ack_d;
            a_rdata_q   <= a_rdata_d;
            b_rdata_q   <= b_rdata_d;
            busy_q      <= busy_d;
            btn_meta_q  <= btn_meta_d;
            btn_sync_q  <= btn_sync_d;
        end
    end

    assign a_rdata   = a_rdata_q;
    assign a_ready   = a_ready_q;
    assign b_rdata   = b_rdata_q;
    assign b_ack     = b_ack_q;
    assign mem_cs    = mem_cs_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign hex_out   = hex_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: a behavioural RAM plus a scoreboard of
// expected completions (requester and read data) checked when each ack arrives.
module tb_ram_port_arbiter;

    logic        clk = 1'b0;
    logic        RAMclr;
    logic        a_sel, a_ld, b_req, b_we;
    logic [11:0] a_addr, b_addr;
    logic [15:0] a_wdata, b_wdata, a_rdata, b_rdata;
    logic        a_ready, b_ack;
    logic        mem_cs, mem_we;
    logic [5:0]  mem_addr;
    logic [15:0] mem_wdata, mem_rdata, hex_out;
    logic [1:0]  btn;
    logic        busy;

    typedef struct packed {
        logic        is_b;
        logic [15:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          cs_cnt   = 0;
    logic        bad_commit = 1'b0;
    logic [15:0] ram [64];

    always #5 clk = ~clk;

    ram_port_arbiter dut (
        .clk(clk), .RAMclr(RAMclr),
        .a_sel(a_sel), .a_ld(a_ld), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(a_rdata), .a_ready(a_ready),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(b_rdata), .b_ack(b_ack),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .btn(btn), .hex_out(hex_out), .busy(busy)
    );

    // Single-port synchronous RAM with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_cs) begin
            cs_cnt <= cs_cnt + 1;
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
            if (mem_we && mem_addr == 6'd9 && mem_wdata == 16'h5555) bad_commit <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit is_b, input bit wr, input logic [11:0] addr,
                         input logic [15:0] wd, input logic [15:0] exp_rd);
        exp_t e;
        e.is_b  = is_b;
        e.rdata = exp_rd;
        exp_q.push_back(e);
        if (is_b) begin
            b_req = 1'b1; b_we = wr; b_addr = addr; b_wdata = wd;
        end else begin
            a_sel = 1'b1; a_ld = !wr; a_addr = addr; a_wdata = wd;
        end
    endtask

    task automatic wait_resp(input int exp_lat, input string tag);
        exp_t        e;
        int          n;
        logic        got, other;
        logic [15:0] rd;
        e   = exp_q[0];
        got = 1'b0;
        n   = 0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            got = e.is_b ? b_ack : a_ready;
        end
        void'(exp_q.pop_front());
        check({tag, " ack"}, 32'(got), 32'd1);
        if (got) begin
            rd    = e.is_b ? b_rdata : a_rdata;
            other = e.is_b ? a_ready : b_ack;
            check({tag, " rdata"}, 32'(rd), 32'(e.rdata));
            check({tag, " other ack"}, 32'(other), 32'd0);
            if (exp_lat > 0) check({tag, " latency"}, n, exp_lat);
        end
        if (e.is_b) b_req = 1'b0;
        else        a_sel = 1'b0;
    endtask

    task automatic access(input bit is_b, input bit wr, input logic [11:0] addr,
                          input logic [15:0] wd, input logic [15:0] exp_rd, input string tag);
        @(negedge clk);
        drive(is_b, wr, addr, wd, exp_rd);
        wait_resp(3, tag);
    endtask

    initial begin
        int   cs0, acks, n;
        logic prev_a, prev_b;
        exp_t e;

        RAMclr = 1'b1;
        a_sel = 0; a_ld = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
        btn = 2'b11;

        // Reset state
        @(negedge clk);
        check("reset busy", 32'(busy), 32'd1);
        check("reset mem", {mem_cs, mem_we, mem_addr, mem_wdata}, 32'd0);
        check("reset hex", 32'(hex_out), 32'd0);
        check("reset acks", {a_ready, b_ack}, 32'd0);
        check("reset rdata", {a_rdata, b_rdata}, 32'd0);

        // Zero-fill sweep with a CPU read held pending throughout
        drive(1'b0, 1'b0, 12'd5, 16'h0, 16'h0000);
        @(negedge clk);
        RAMclr = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            check($sformatf("clear cycle %0d", i),
                  {busy, mem_cs, mem_we, a_ready, mem_addr, mem_wdata},
                  {1'b1, 1'b1, 1'b1, 1'b0, 6'(i), 16'h0});
        end
        @(negedge clk);
        check("busy falls", 32'(busy), 32'd0);
        wait_resp(2, "held read 5");

        // RAM write then read back
        cs0 = cs_cnt;
        access(1'b0, 1'b1, 12'd5, 16'hBEEF, 16'h0000, "write 5");
        check("write 5 one mem cycle", cs_cnt - cs0, 32'd1);
        check("write 5 ram content", 32'(ram[5]), 32'h0000_BEEF);
        access(1'b0, 1'b0, 12'd5, 16'h0, 16'hBEEF, "read 5");

        // Display register
        cs0 = cs_cnt;
        access(1'b0, 1'b1, 12'd1, 16'h1234, 16'h0000, "write hex");
        check("hex value", 32'(hex_out), 32'h0000_1234);
        access(1'b0, 1'b0, 12'd1, 16'h0, 16'h1234, "read hex");
        check("hex no mem cycle", cs_cnt - cs0, 32'd0);

        // Buttons through the synchronizer; address 0 is read-only
        btn = 2'b10;
        repeat (3) @(negedge clk);
        cs0 = cs_cnt;
        access(1'b0, 1'b0, 12'd0, 16'h0, 16'h0001, "read btn");
        access(1'b0, 1'b1, 12'd0, 16'hFFFF, 16'h0000, "write btn");
        access(1'b1, 1'b0, 12'd0, 16'h0, 16'h0001, "b read btn");
        check("btn no mem cycle", cs_cnt - cs0, 32'd0);
        check("btn write no hex change", 32'(hex_out), 32'h0000_1234);
        btn = 2'b11;

        // Continuous contention: expect A,B,A,B
        @(negedge clk);
        a_sel = 1'b1; a_ld = 1'b0; a_addr = 12'd20; a_wdata = 16'h1111;
        b_req = 1'b1; b_we = 1'b0; b_addr = 12'd5;  b_wdata = 16'h0;
        for (int k = 0; k < 4; k++) begin
            e.is_b  = (k % 2) == 1;
            e.rdata = e.is_b ? 16'hBEEF : 16'h0000;
            exp_q.push_back(e);
        end
        acks = 0; n = 0; prev_a = 1'b0; prev_b = 1'b0;
        while (acks < 4 && n < 60) begin
            @(negedge clk);
            n++;
            if (a_ready || b_ack) begin
                e = exp_q.pop_front();
                check($sformatf("contend %0d one ack", acks), 32'(a_ready & b_ack), 32'd0);
                check($sformatf("contend %0d who", acks), 32'(b_ack), 32'(e.is_b));
                check($sformatf("contend %0d rdata", acks),
                      32'(b_ack ? b_rdata : a_rdata), 32'(e.rdata));
                check($sformatf("contend %0d pulse", acks),
                      32'((a_ready & prev_a) | (b_ack & prev_b)), 32'd0);
                acks++;
                if (acks == 4) begin
                    a_sel = 1'b0;
                    b_req = 1'b0;
                end
            end
            prev_a = a_ready;
            prev_b = b_ack;
        end
        check("contend ack count", acks, 32'd4);
        @(negedge clk);
        check("contend ack after drop", {a_ready, b_ack}, 32'd0);

        // Reset during the RAM cycle of a write aborts it and restarts zero-fill
        access(1'b0, 1'b1, 12'd9, 16'hAAAA, 16'h0000, "write 9");
        @(negedge clk);
        a_sel = 1'b1; a_ld = 1'b0; a_addr = 12'd9; a_wdata = 16'h5555;
        @(posedge clk);
        #1;
        check("abort write presented", {mem_cs, mem_we, mem_addr, mem_wdata},
              {1'b1, 1'b1, 6'd9, 16'h5555});
        RAMclr = 1'b1;
        #1;
        check("abort mem_cs cleared", 32'(mem_cs), 32'd0);
        a_sel = 1'b0;
        repeat (2) @(negedge clk);
        check("abort no ready", 32'(a_ready), 32'd0);
        check("abort hex cleared", 32'(hex_out), 32'd0);
        RAMclr = 1'b0;
        n = 0;
        prev_a = 1'b0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
            prev_a = prev_a | a_ready;
        end
        check("refill finished", 32'(busy), 32'd0);
        check("refill no ready", 32'(prev_a), 32'd0);
        check("aborted write not committed", 32'(bad_commit), 32'd0);
        access(1'b0, 1'b0, 12'd9, 16'h0, 16'h0000, "read 9 after refill");
        access(1'b0, 1'b0, 12'd100, 16'h0, 16'h0000, "read 100");
        access(1'b1, 1'b0, 12'd5, 16'h0, 16'h0000, "b read 5 after refill");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
